// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: RISC-V immediate extender feeding a 2-entry valid/ready FIFO.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   in_valid/in_ready producer handshake; inst = instruction bits [31:7],
//                     immsrc = format select, in_tag = sideband carried along
//   out_valid/out_ready consumer handshake; imm/out_tag/out_illegal = head entry
//   illegal_cnt       saturating count of accepted entries with immsrc 3'b111
module imm_extend_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [24:0]      inst,
    input  logic [2:0]       immsrc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);
    // Renumbered so field slices read exactly like the instruction encoding.
    logic [31:7]      ins;
    logic [XLEN-1:0]  ext;
    logic             ill;
    logic             push;
    logic             pop;
    logic [1:0]       count_q, count_d;
    logic [XLEN-1:0]  h_imm_q, h_imm_d, t_imm_q, t_imm_d;
    logic [TAG_W-1:0] h_tag_q, h_tag_d, t_tag_q, t_tag_d;
    logic             h_ill_q, h_ill_d, t_ill_q, t_ill_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_head;
    logic             to_tail;

    assign ins = inst;
    assign ill = immsrc == 3'b111;

    // Signed size casts sign-extend from the top bit of each field to XLEN.
    always_comb begin
        case (immsrc)
            3'b000:  ext = XLEN'($signed(ins[31:20]));
            3'b001:  ext = XLEN'($signed({ins[31:25], ins[11:7]}));
            3'b010:  ext = XLEN'($signed({ins[31:12], 12'b0}));
            3'b011:  ext = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            3'b100:  ext = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            3'b101:  ext = XLEN == 32 ? XLEN'(ins[24:20]) : XLEN'(ins[25:20]);
            3'b110:  ext = XLEN'(ins[19:15]);
            default: ext = '0;
        endcase
    end

    assign in_ready  = !reset && count_q != 2'd2;
    assign out_valid = count_q != 2'd0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // New entry lands in the head when the FIFO is (or becomes) empty of older
    // entries; otherwise it queues behind the head. A pop shifts tail to head.
    assign to_head = push && (count_q == 2'd0 || (count_q == 2'd1 && pop));
    assign to_tail = push && count_q == 2'd1 && !pop;

    always_comb begin
        h_imm_d = to_head ? ext    : pop ? t_imm_q : h_imm_q;
        h_tag_d = to_head ? in_tag : pop ? t_tag_q : h_tag_q;
        h_ill_d = to_head ? ill    : pop ? t_ill_q : h_ill_q;
        t_imm_d = to_tail ? ext    : t_imm_q;
        t_tag_d = to_tail ? in_tag : t_tag_q;
        t_ill_d = to_tail ? ill    : t_ill_q;
        count_d = count_q + 2'(push) - 2'(pop);
        cnt_d   = (push && ill && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            h_imm_q <= '0;
            h_tag_q <= '0;
            h_ill_q <= 1'b0;
            t_imm_q <= '0;
            t_tag_q <= '0;
            t_ill_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            count_q <= count_d;
            h_imm_q <= h_imm_d;
            h_tag_q <= h_tag_d;
            h_ill_q <= h_ill_d;
            t_imm_q <= t_imm_d;
            t_tag_q <= t_tag_d;
            t_ill_q <= t_ill_d;
            cnt_q   <= cnt_d;
        end
    end

    // Head fields read as zero when nothing is stored, so drained entries never linger.
    assign imm         = out_valid ? h_imm_q : '0;
    assign out_tag     = out_valid ? h_tag_q : '0;
    assign out_illegal = out_valid && h_ill_q;
    assign illegal_cnt = cnt_q;
endmodule
